// File: rtl/rx_receiver_pkg.sv
// Shared definitions for the serial frame link (receiver side).
// Frame on the wire, MSB first: preamble, SFD, header, payload, CRC-8.
package rx_receiver_pkg;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_CRC    = 2'd3
  } rx_state_e;

  // Line patterns shared with tx_transmitter
  localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
  localparam logic [7:0]  SFD_PATTERN      = 8'hAB;

  // Header field positions
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;

  // Index of the last payload bit for a header length field: (len+1)*8-1,
  // kept in 8 bits (maximum 127).
  function automatic logic [7:0] payload_last_bit(input logic [3:0] len);
    logic [7:0] bytes;
    bytes = {4'd0, len} + 8'd1;
    return (bytes << 3) - 8'd1;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (polynomial x^8+x^2+x+1, init 0x00, MSB first).
// clear has priority over enable.
module crc8_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out
);

  localparam logic [7:0] CRC8_POLY = 8'h07;

  logic feedback;

  assign feedback = crc_out[7] ^ data_in;

  // Clear or advance the CRC remainder by one bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= 8'h00;
    end else if (clear) begin
      crc_out <= 8'h00;
    end else if (enable) begin
      crc_out <= {crc_out[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rx_receiver.sv
// Serial frame receiver: hunts for preamble tail + SFD, deserialises
// header, variable-length payload and CRC-8, and presents the packet with
// a one-cycle valid pulse and a CRC error flag.
// Optional: define RX_STATS_EN to add good/error frame counters.
module rx_receiver
  import rx_receiver_pkg::*;
#(
  parameter int PRE_MIN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_line,
  output logic [135:0] rx_packet,
  output logic         rx_valid,
  output logic         crc_err,
  output logic         rx_busy
`ifdef RX_STATS_EN
  ,
  output logic [7:0]   good_cnt,
  output logic [7:0]   err_cnt
`endif
);

  localparam int WIN_W = PRE_MIN + 8;
  localparam logic [23:0] SYNC_FULL = {PREAMBLE_PATTERN, SFD_PATTERN};
  localparam logic [WIN_W-1:0] SYNC_PAT = SYNC_FULL[WIN_W-1:0];

  rx_state_e        state, state_nxt;
  logic [7:0]       bit_cnt, bit_cnt_nxt;
  // Only the older WIN_W-1 bits are stored; the newest is rx_line itself,
  // so the match fires on the cycle the last SFD bit is on the line.
  logic [WIN_W-2:0] sync_hist;
  logic [WIN_W-1:0] sync_win;
  logic             sync_hit;
  logic [3:0]       len;
  logic [7:0]       data_last;
  logic [7:0]       header;
  logic [127:0]     payload;
  logic [6:0]       crc_rx;
  logic             crc_clear;
  logic             crc_en;
  logic [7:0]       crc_out;
  logic             crc_match;
  logic             frame_done;

  assign sync_win  = {sync_hist, rx_line};
  assign sync_hit  = (state == S_HUNT) && (sync_win == SYNC_PAT);
  assign data_last = payload_last_bit(len);
  assign crc_match = ({crc_rx, rx_line} == crc_out);
  assign rx_busy   = (state != S_HUNT);

  crc8_serial u_crc_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (rx_line),
    .crc_out (crc_out)
  );

  // Next-state, bit counter and CRC control
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    frame_done  = 1'b0;
    case (state)
      S_HUNT: begin
        crc_clear = 1'b1;
        if (sync_hit) begin
          state_nxt   = S_HEADER;
          bit_cnt_nxt = 8'd0;
        end
      end
      S_HEADER: begin
        if (bit_cnt == 8'd7) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = 8'd0;
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
        end
      end
      S_DATA: begin
        crc_en = 1'b1;
        if (bit_cnt == data_last) begin
          state_nxt   = S_CRC;
          bit_cnt_nxt = 8'd0;
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
        end
      end
      S_CRC: begin
        if (bit_cnt == 8'd7) begin
          frame_done  = 1'b1;
          state_nxt   = S_HUNT;
          bit_cnt_nxt = 8'd0;
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt   = S_HUNT;
        bit_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Control registers: state, counter, sync window, latched length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      bit_cnt   <= 8'd0;
      sync_hist <= '0;
      len       <= 4'd0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      // Window runs only while hunting and restarts empty on every entry
      if (state == S_HUNT && !sync_hit) begin
        sync_hist <= sync_win[WIN_W-2:0];
      end else begin
        sync_hist <= '0;
      end
      if (state == S_HEADER && bit_cnt == 8'd7) begin
        len <= {header[HDR_LEN_MSB-1:HDR_LEN_LSB], rx_line};
      end
    end
  end

  // Deserialising shift registers for header, payload and received CRC
  always_ff @(posedge clk) begin
    case (state)
      S_HUNT: begin
        if (sync_hit) begin
          payload <= '0;
        end
      end
      S_HEADER: header <= {header[6:0], rx_line};
      S_DATA:   payload[~bit_cnt[6:0]] <= rx_line;
      S_CRC:    crc_rx <= {crc_rx[5:0], rx_line};
      default:  ;
    endcase
  end

  // Frame output registers, updated the cycle after the last CRC bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_packet <= '0;
      rx_valid  <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        rx_packet <= {header, payload};
        crc_err   <= !crc_match;
      end
    end
  end

`ifdef RX_STATS_EN
  // Saturating good/error frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= 8'd0;
      err_cnt  <= 8'd0;
    end else if (rx_valid) begin
      if (crc_err) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else begin
        if (good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rx_receiver.md
Name: rx_receiver

Overview:
- Serial frame receiver; the receive-side counterpart of tx_transmitter on the single-bit line.
- Hunts for preamble+SFD, then deserialises header, variable-length payload and CRC-8, checks the CRC, and presents a 136-bit packet with a one-cycle valid pulse.
- Frame format, MSB first: preamble 16'hAAAA, SFD 8'hAB, header 8 bits, payload (header[3:0]+1)*8 bits, CRC-8 8 bits.
- Shares the clock with the transmitter; samples one bit per clk, no oversampling.

Parameters:
- PRE_MIN, 8: preamble bits (even, 0..16) that must immediately precede the SFD. The required tail is the low PRE_MIN bits of 16'hAAAA.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_line  input  1  serial line, sampled every rising clk edge.
- rx_packet  output  136  [135:128] header, [127:0] payload left-aligned, unused low bits 0.
- rx_valid  output  1  one-cycle pulse, frame complete.
- crc_err  output  1  valid with rx_valid; 1 = received CRC differs from computed CRC.
- rx_busy  output  1  high in S_HEADER/S_DATA/S_CRC.

Behaviour:
- Reset:
  - state=S_HUNT, all outputs 0, sync window 0, bit_cnt 0, crc clear asserted.
  - Reset applied mid-frame aborts the frame: no rx_valid, packet cleared.
- S_HUNT:
  - Shift rx_line into a (PRE_MIN+8)-bit window, LSB in.
  - On the cycle the window equals {preamble tail, 8'hAB}: go to S_HEADER, bit_cnt=0.
  - Hold crc8_serial clear=1 throughout.
  - The window is zeroed on every entry to S_HUNT so stale bits cannot match.
- S_HEADER:
  - 8 bits MSB first into the header register.
  - At bit_cnt==7: latch len=header[3:0] from the completed byte; go to S_DATA, bit_cnt=0.
- S_DATA:
  - Received bit k is written to payload[127-k].
  - crc8_serial enable=1, data_in=rx_line; CRC covers the payload only.
  - Exit at bit_cnt==(len+1)*8-1 to S_CRC, bit_cnt=0.
  - Length arithmetic is done in 8 bits; max 127.
- S_CRC:
  - Shift 8 bits MSB first into crc_rx; crc enable=0.
  - At bit_cnt==7, compare {crc_rx[6:0],rx_line} with crc_out.
  - Next cycle: rx_valid=1, crc_err=mismatch, rx_packet updated; go to S_HUNT.
- Outputs and latency:
  - rx_packet holds until the next completed frame.
  - rx_valid asserts exactly 1 clk after the last CRC bit is sampled.
  - crc_err holds until the next rx_valid.
  - The payload register is cleared on SFD detect so short frames leave zeros in the unused bits.
- Back-to-back frames: a frame starting 1 idle cycle after the previous CRC must be caught. Entering S_HUNT in the cycle after the last CRC bit satisfies this.
- No timeout: a truncated frame stalls in S_DATA until the bit count completes or reset.

Optional Feature:
- RX_STATS_EN defined:
  - Adds outputs good_cnt[7:0] and err_cnt[7:0].
  - Each increments on rx_valid according to crc_err, saturating at 255; reset to 0.
- RX_STATS_EN undefined: ports and logic absent, behaviour otherwise identical.

Decomposition:
- Shared package/include:
  - State encodings S_HUNT/S_HEADER/S_DATA/S_CRC.
  - PREAMBLE_PATTERN 16'hAAAA and SFD_PATTERN 8'hAB, shared with the transmitter.
  - Header field positions (len = [3:0]).
- Sub-module: reuse the existing crc8_serial (clear, enable, data_in, crc_out) as u_crc_rx; no new sub-module.

Test Plan:
- Loopback via tx_transmitter, header 8'h10, payload byte 8'hA5 -> rx_valid pulse, rx_packet[135:128]=8'h10, [127:120]=8'hA5, [119:0]=0, crc_err=0.
- Header 8'h0F, 128-bit payload 128'h0123...CDEF, then a second frame 1 idle cycle later -> two rx_valid pulses, both payloads exact, crc_err=0.
- tx test_mode=1 (first data bit inverted) -> rx_valid with crc_err=1; payload bit 127 inverted.
- Hand-driven frame with only 4 preamble bits (PRE_MIN=8) -> no rx_valid; the next full frame is received.
- rst_n low for 2 clks at payload bit 20 -> outputs 0, no rx_valid; the following frame is received correctly.
- RX_STATS_EN: 3 good frames + 1 test_mode frame -> good_cnt=3, err_cnt=1; 300 good frames -> good_cnt=255.
